// File: rtl/add16_mul_seq.sv
//-----------------------------------------------------------------------------
// add16_mul_seq -- 16x16 shift-and-add multiplier returning the low 16 bits.
//
// One add16 instance performs every accumulation; the sequencer walks the
// multiplier one bit per RUN cycle, and the accumulator register drives the
// product output directly.
//
// Build option: define MUL_EARLY_TERM_EN to stop RUN as soon as the remaining
// multiplier bits are all zero. Without it every operation takes 16 RUN
// cycles. The product value is identical in both builds.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module add16 #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    // Modulo-2^W sum: the carry out is dropped on purpose, so overflow wraps.
    assign o_sum = i_a + i_b;

endmodule

module add16_mul_seq #(
    parameter int WIDTH = 16    // only 16 is supported
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index of the final RUN cycle in the fixed-length schedule.
    localparam logic [3:0] LAST_COUNT = 4'd15;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [3:0]       r_count;

    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_mcand_next;
    logic [WIDTH-1:0] w_mplier_next;
    logic             w_run_last;
    logic             w_ready_next;
    logic             w_busy_next;
    logic             w_done_next;

    // The only adder in the datapath: accumulator plus shifted multiplicand.
    add16 #(.W(WIDTH)) u_add16 (
        .i_a   (r_acc),
        .i_b   (r_mcand),
        .o_sum (w_sum)
    );

    assign w_mcand_next  = r_mcand << 1;
    assign w_mplier_next = r_mplier >> 1;

`ifdef MUL_EARLY_TERM_EN
    // Stop once no set multiplier bits remain after this cycle's shift; the
    // count limit still bounds the run when b has its top bit set.
    assign w_run_last = (r_count == LAST_COUNT) || (w_mplier_next == '0);
`else
    // Fixed schedule: always 16 RUN cycles regardless of operand values.
    assign w_run_last = (r_count == LAST_COUNT);
`endif

    // State register: reset aborts any operation and returns to IDLE at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_run_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, so the status flags can be
    // registered and still line up exactly with the state they describe.
    always_comb begin
        w_ready_next = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (w_next_state)
            ST_IDLE: w_ready_next = 1'b1;
            ST_RUN:  w_busy_next  = 1'b1;
            ST_DONE: w_done_next  = 1'b1;
            default: w_ready_next = 1'b1;
        endcase
    end

    // Status flag registers; reset presents the idle indication.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= w_ready_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Datapath: load operands on an accepted start, then one shift-and-add
    // step per RUN cycle; everything holds in DONE and while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_count  <= 4'd0;
                    end
                end
                ST_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= w_sum;
                    end
                    r_mcand  <= w_mcand_next;
                    r_mplier <= w_mplier_next;
                    r_count  <= r_count + 4'd1;
                end
                ST_DONE: begin
                    r_count <= r_count;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: tb/tb_add16_mul_seq.sv
//-----------------------------------------------------------------------------
// Self-checking bench for add16_mul_seq. Expected products come from plain
// arithmetic (a*b mod 2^16); expected latency comes from the bit length of b
// when MUL_EARLY_TERM_EN is defined, otherwise it is 16.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_add16_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int test_cnt = 0;
    int fail_cnt = 0;
    int done_cnt = 0;

    add16_mul_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference product: full multiply, keep the low 16 bits.
    function automatic logic [15:0] model_product(input logic [15:0] x, input logic [15:0] y);
        longint full;
        full = longint'(x) * longint'(y);
        return 16'(full);
    endfunction

    // Reference RUN length for multiplier y.
    function automatic int model_latency(input logic [15:0] y);
        int n;
        n = 16;
`ifdef MUL_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < 16; i++) begin
            if (y[i]) n = i + 1;
        end
`endif
        return n;
    endfunction

    // Every cycle exactly one status flag is high; also count done pulses.
    always @(negedge clk) begin
        check_eq("onehot", int'(ready) + int'(busy) + int'(done), 1);
        if (done === 1'b1) done_cnt++;
    end

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_rdy_wait"}, ready, 1);
    endtask

    // Full operation with latency, product and post-done checks.
    task automatic do_op(input logic [15:0] op_a, input logic [15:0] op_b, input string tag);
        logic [15:0] exp_p;
        int exp_lat;
        int lat;
        int d0;
        exp_p   = model_product(op_a, op_b);
        exp_lat = model_latency(op_b);
        wait_ready(tag);
        a = op_a; b = op_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        check_eq({tag, "_busy"}, busy, 1);
        check_eq({tag, "_clr"}, product, 0);
        d0  = done_cnt;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_prod"}, product, exp_p);
        @(posedge clk); #1;
        check_eq({tag, "_flags"}, {ready, busy, done}, 3'b100);
        check_eq({tag, "_hold"}, product, exp_p);
        check_eq({tag, "_ndone"}, done_cnt - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int lat;
        int exp_lat;
        int pulse;
        logic [15:0] ra;
        logic [15:0] rb;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = 16'h0;
        b       = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_flags", {ready, busy, done}, 3'b100);
        check_eq("rst_prod", product, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed operand cases.
        do_op(16'd3,     16'd5,     "a3b5");
        check_eq("a3b5_const", product, 16'h000F);
        do_op(16'hFFFF,  16'hFFFF,  "ffff");
        check_eq("ffff_const", product, 16'h0001);
        do_op(16'd300,   16'd300,   "a300");
        check_eq("a300_const", product, 16'h5F90);
        do_op(16'h0100,  16'h0003,  "early3");
        do_op(16'hABCD,  16'h0000,  "bzero");
        do_op(16'h1234,  16'h8000,  "btop");

        // start pulsed during RUN must be ignored.
        wait_ready("ign");
        a = 16'd2; b = 16'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        d0 = done_cnt;
        exp_lat = model_latency(16'd9);
        pulse = (exp_lat > 5) ? 5 : 1;
        repeat (pulse) begin @(posedge clk); #1; end
        a = 16'd7; b = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = pulse + 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("ign_lat", lat, exp_lat);
        check_eq("ign_prod", product, 16'h0012);
        repeat (4) begin @(posedge clk); #1; end
        check_eq("ign_idle", {ready, busy, done}, 3'b100);
        check_eq("ign_hold", product, 16'h0012);
        check_eq("ign_ndone", done_cnt - d0, 1);

        // Reset in the middle of RUN aborts the operation.
        wait_ready("rst");
        a = 16'h1234; b = 16'h0101; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check_eq("rst_run_busy", busy, 1);
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_async_flags", {ready, busy, done}, 3'b100);
        check_eq("rst_async_prod", product, 0);
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        check_eq("rst_nodone", done_cnt - d0, 0);
        check_eq("rst_idle", {ready, busy, done}, 3'b100);
        check_eq("rst_prod_zero", product, 0);
        do_op(16'd4, 16'd4, "post_rst");
        check_eq("post_rst_const", product, 16'h0010);

        // Randomized operations, with a spread of multiplier bit lengths.
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            do_op(ra, rb, "rand");
        end

        // start held high: a new operation in every IDLE cycle.
        wait_ready("b2b");
        start = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            a = ra; b = rb;
            @(posedge clk); #1;
            a = 16'($urandom);
            b = 16'($urandom);
            check_eq("b2b_busy", busy, 1);
            lat = 0;
            while (done !== 1'b1 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check_eq("b2b_lat", lat, model_latency(rb));
            check_eq("b2b_prod", product, model_product(ra, rb));
            @(posedge clk); #1;
            check_eq("b2b_idle", {ready, busy, done}, 3'b100);
        end
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("b2b_ndone", done_cnt - d0, 4);
        check_eq("b2b_end_idle", ready, 1);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
